// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS_cache pipeline: widths, ALU command and
// branch type encodings, and the all-zero NOP control bundle.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CMD_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        EXE_ADD   = 4'b0000,
        EXE_SUB   = 4'b0010,
        EXE_AND   = 4'b0100,
        EXE_OR    = 4'b0101,
        EXE_NOR   = 4'b0110,
        EXE_XOR   = 4'b0111,
        EXE_SLA   = 4'b1000,
        EXE_SRA   = 4'b1001,
        EXE_SRL   = 4'b1010,
        EXE_NO_OP = 4'b1111
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    // Control bundle carried from ID to EXE; a squashed slot carries all zeros
    typedef struct packed {
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [REG_W-1:0] dst;
        logic [CMD_W-1:0] exe_cmd;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             is_immediate;
        logic             sw;
        logic [1:0]       br_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register slice: synchronous active-low reset, hold when
// en is low, and clear-to-zero (bubble) when clr is high.
module pipe_reg
    import mips_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins, then a held (disabled) stage, then clear, then load
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: carries decoded fields and operands into EXE,
// supports cache freeze, branch flush and load-use bubbles, and counts the
// bubbles it inserts with a saturating counter.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] Val1_in,
    input  logic [DATA_W-1:0] Val2_in,
    input  logic [DATA_W-1:0] Imm_in,
    input  logic [REG_W-1:0]  Src1_in,
    input  logic [REG_W-1:0]  Src2_in,
    input  logic [REG_W-1:0]  Dst_in,
    input  logic [CMD_W-1:0]  EXE_CMD_in,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              is_immediate_in,
    input  logic              sw_in,
    input  logic [1:0]        Br_type_in,
    output logic [DATA_W-1:0] PC_EXE,
    output logic [DATA_W-1:0] Val1_EXE,
    output logic [DATA_W-1:0] Val2_EXE,
    output logic [DATA_W-1:0] Imm_EXE,
    output logic [REG_W-1:0]  Src1_EXE,
    output logic [REG_W-1:0]  Src2_EXE,
    output logic [REG_W-1:0]  Dst_EXE,
    output logic [CMD_W-1:0]  EXE_CMD_EXE,
    output logic              WB_EN_EXE,
    output logic              Mem_read_EXE,
    output logic              Mem_write_EXE,
    output logic              is_immediate_EXE,
    output logic              sw_EXE,
    output logic [1:0]        Br_type_EXE,
    output logic              valid_EXE,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import mips_pkg::*;

    localparam int DBUS_W = 4 * DATA_W;
    localparam int CBUS_W = 3 * REG_W + CMD_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              stage_en;
    logic              bubble;
    logic [DBUS_W-1:0] data_d;
    logic [DBUS_W-1:0] data_q;
    logic [CBUS_W-1:0] ctrl_d;
    logic [CBUS_W-1:0] ctrl_q;

    assign stage_en = ~freeze;
    assign bubble   = flush | hazard;

    assign data_d = {PC_in, Val1_in, Val2_in, Imm_in};
    assign ctrl_d = {Src1_in, Src2_in, Dst_in, EXE_CMD_in, WB_EN_in, MEM_R_EN_in,
                     MEM_W_EN_in, is_immediate_in, sw_in, Br_type_in};

    // Operand values always load when unfrozen; they are meaningless in a bubble
    pipe_reg #(.W(DBUS_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (1'b0),
        .d   (data_d),
        .q   (data_q)
    );

    // Control and register indices clear in a bubble so forwarding never matches
    pipe_reg #(.W(CBUS_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (stage_en),
        .clr (bubble),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    assign {PC_EXE, Val1_EXE, Val2_EXE, Imm_EXE} = data_q;
    assign {Src1_EXE, Src2_EXE, Dst_EXE, EXE_CMD_EXE, WB_EN_EXE, Mem_read_EXE,
            Mem_write_EXE, is_immediate_EXE, sw_EXE, Br_type_EXE} = ctrl_q;

    // Valid bit and saturating bubble counter; flush and hazard together count once
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_EXE  <= 1'b0;
            bubble_cnt <= '0;
        end else if (!freeze) begin
            valid_EXE <= ~bubble;
            if (bubble && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Testbench for id_exe_stage_reg: directed scenarios followed by random
// traffic, all checked against a behavioural model of the EXE-side state.
module tb_id_exe_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int CNT_SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, hazard;
    logic [DW-1:0] PC_in, Val1_in, Val2_in, Imm_in;
    logic [RW-1:0] Src1_in, Src2_in, Dst_in;
    logic [CW-1:0] EXE_CMD_in;
    logic          WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, is_immediate_in, sw_in;
    logic [1:0]    Br_type_in;
    logic [DW-1:0] PC_EXE, Val1_EXE, Val2_EXE, Imm_EXE;
    logic [RW-1:0] Src1_EXE, Src2_EXE, Dst_EXE;
    logic [CW-1:0] EXE_CMD_EXE;
    logic          WB_EN_EXE, Mem_read_EXE, Mem_write_EXE, is_immediate_EXE, sw_EXE;
    logic [1:0]    Br_type_EXE;
    logic          valid_EXE;
    logic [NW-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model of what EXE should be holding
    logic [DW-1:0] m_pc, m_v1, m_v2, m_imm;
    logic [RW-1:0] m_s1, m_s2, m_dst;
    logic [CW-1:0] m_cmd;
    logic          m_wb, m_mr, m_mw, m_immf, m_sw;
    logic [1:0]    m_br;
    logic          m_valid;
    int            m_cnt;
    int            c0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(DW), .REG_W(RW), .CMD_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .PC_in(PC_in), .Val1_in(Val1_in), .Val2_in(Val2_in), .Imm_in(Imm_in),
        .Src1_in(Src1_in), .Src2_in(Src2_in), .Dst_in(Dst_in), .EXE_CMD_in(EXE_CMD_in),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .is_immediate_in(is_immediate_in), .sw_in(sw_in), .Br_type_in(Br_type_in),
        .PC_EXE(PC_EXE), .Val1_EXE(Val1_EXE), .Val2_EXE(Val2_EXE), .Imm_EXE(Imm_EXE),
        .Src1_EXE(Src1_EXE), .Src2_EXE(Src2_EXE), .Dst_EXE(Dst_EXE),
        .EXE_CMD_EXE(EXE_CMD_EXE), .WB_EN_EXE(WB_EN_EXE), .Mem_read_EXE(Mem_read_EXE),
        .Mem_write_EXE(Mem_write_EXE), .is_immediate_EXE(is_immediate_EXE),
        .sw_EXE(sw_EXE), .Br_type_EXE(Br_type_EXE), .valid_EXE(valid_EXE),
        .bubble_cnt(bubble_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic setId(input logic [DW-1:0] pc, input logic [RW-1:0] s1, s2, d,
                         input logic wb, mr);
        PC_in = pc; Val1_in = $urandom; Val2_in = $urandom; Imm_in = $urandom;
        Src1_in = s1; Src2_in = s2; Dst_in = d; EXE_CMD_in = 4'h0;
        WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = 1'b0;
        is_immediate_in = 1'b0; sw_in = 1'b0; Br_type_in = 2'b00;
    endtask

    task automatic randomizeId();
        PC_in = $urandom; Val1_in = $urandom; Val2_in = $urandom; Imm_in = $urandom;
        Src1_in = RW'($urandom); Src2_in = RW'($urandom); Dst_in = RW'($urandom);
        EXE_CMD_in = CW'($urandom); WB_EN_in = 1'($urandom); MEM_R_EN_in = 1'($urandom);
        MEM_W_EN_in = 1'($urandom); is_immediate_in = 1'($urandom);
        sw_in = 1'($urandom); Br_type_in = 2'($urandom);
    endtask

    // What one rising edge should do: reset, hold, bubble, or load
    task automatic modelEdge();
        if (!rst) begin
            {m_pc, m_v1, m_v2, m_imm} = '0;
            {m_s1, m_s2, m_dst, m_cmd, m_wb, m_mr, m_mw, m_immf, m_sw, m_br} = '0;
            m_valid = 1'b0;
            m_cnt = 0;
        end else if (!freeze) begin
            m_pc = PC_in; m_v1 = Val1_in; m_v2 = Val2_in; m_imm = Imm_in;
            if (flush || hazard) begin
                {m_s1, m_s2, m_dst, m_cmd, m_wb, m_mr, m_mw, m_immf, m_sw, m_br} = '0;
                m_valid = 1'b0;
                m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
            end else begin
                m_s1 = Src1_in; m_s2 = Src2_in; m_dst = Dst_in; m_cmd = EXE_CMD_in;
                m_wb = WB_EN_in; m_mr = MEM_R_EN_in; m_mw = MEM_W_EN_in;
                m_immf = is_immediate_in; m_sw = sw_in; m_br = Br_type_in;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("PC_EXE", PC_EXE, m_pc);
        checkOutput("Val1_EXE", Val1_EXE, m_v1);
        checkOutput("Val2_EXE", Val2_EXE, m_v2);
        checkOutput("Imm_EXE", Imm_EXE, m_imm);
        checkOutput("Src1_EXE", 32'(Src1_EXE), 32'(m_s1));
        checkOutput("Src2_EXE", 32'(Src2_EXE), 32'(m_s2));
        checkOutput("Dst_EXE", 32'(Dst_EXE), 32'(m_dst));
        checkOutput("EXE_CMD_EXE", 32'(EXE_CMD_EXE), 32'(m_cmd));
        checkOutput("ctrl_bits", {27'd0, WB_EN_EXE, Mem_read_EXE, Mem_write_EXE,
                    is_immediate_EXE, sw_EXE}, {27'd0, m_wb, m_mr, m_mw, m_immf, m_sw});
        checkOutput("Br_type_EXE", 32'(Br_type_EXE), 32'(m_br));
        checkOutput("valid_EXE", 32'(valid_EXE), 32'(m_valid));
        checkOutput("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle's control inputs, let the edge happen, then compare
    task automatic applyStimulus(input logic r, input logic f, input logic fl, input logic hz);
        rst = r; freeze = f; flush = fl; hazard = hz;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        m_cnt = 0; m_valid = 1'b0;
        {m_pc, m_v1, m_v2, m_imm} = '0;
        {m_s1, m_s2, m_dst, m_cmd, m_wb, m_mr, m_mw, m_immf, m_sw, m_br} = '0;
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;

        // Reset with every input high, including a freeze pulse
        PC_in = '1; Val1_in = '1; Val2_in = '1; Imm_in = '1;
        Src1_in = '1; Src2_in = '1; Dst_in = '1; EXE_CMD_in = '1;
        WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
        is_immediate_in = 1'b1; sw_in = 1'b1; Br_type_in = 2'b11;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_valid", 32'(valid_EXE), 32'd0);
        checkOutput("rst_cnt", 32'(bubble_cnt), 32'd0);
        checkOutput("rst_pc", PC_EXE, 32'd0);

        // Normal load
        setId(32'h0000_0010, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load_pc", PC_EXE, 32'h10);
        checkOutput("load_src1", 32'(Src1_EXE), 32'd3);
        checkOutput("load_dst", 32'(Dst_EXE), 32'd5);
        checkOutput("load_memrd", 32'(Mem_read_EXE), 32'd1);
        checkOutput("load_valid", 32'(valid_EXE), 32'd1);

        // Freeze holds through a pending flush, which lands on release
        setId(32'h20, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        c0 = m_cnt;
        setId(32'h24, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput("frz_dst", 32'(Dst_EXE), 32'd7);
            checkOutput("frz_cnt", 32'(bubble_cnt), 32'(c0));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("rel_wb", 32'(WB_EN_EXE), 32'd0);
        checkOutput("rel_dst", 32'(Dst_EXE), 32'd0);
        checkOutput("rel_cnt", 32'(bubble_cnt), 32'(c0 + 1));

        // Hazard bubble after a fresh reset
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        setId(32'h30, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("hz_memrd", 32'(Mem_read_EXE), 32'd0);
        checkOutput("hz_dst", 32'(Dst_EXE), 32'd0);
        checkOutput("hz_valid", 32'(valid_EXE), 32'd0);
        checkOutput("hz_cnt", 32'(bubble_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hz_reload_dst", 32'(Dst_EXE), 32'd8);

        // Flush and hazard together count as one bubble
        c0 = 32'(bubble_cnt);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("both_cnt", 32'(bubble_cnt), 32'(c0 + 1));

        // Saturation
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("sat_cnt", 32'(bubble_cnt), 32'(CNT_SAT));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            randomizeId();
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
